// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit.
//   - opcode / funct encodings of the supported instructions
//   - ALU operation codes, FSM state encodings
//   - datapath mux-select encodings
//   - instruction class vector produced by mc_instr_class
package mc_pkg;

    localparam int ALU_OP_WIDTH = 4;
    localparam int STATE_WIDTH  = 4;
    localparam int LUI_SHAMT    = 16;  // shift applied by the datapath when shamt_sel=1

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Functs (IR[5:0]) for R-type
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_OR  = 4'b0010,
        ALU_SLL = 4'b0011
    } alu_op_e;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JR     = 4'd12
    } state_e;

    // ALU operand A select
    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;
    // ALU operand B select
    localparam logic [2:0] SRCB_REG     = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_SEXT    = 3'b010;
    localparam logic [2:0] SRCB_ZEXT    = 3'b011;
    localparam logic [2:0] SRCB_SEXT_SH = 3'b100;
    // Register destination select
    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;
    // Write-back data select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_DM  = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;

    typedef struct packed {
        logic r_alu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic bad;
    } instr_class_t;

endpackage

// File: rtl/mc_instr_class.sv
// Combinational instruction classifier.
// Ports:
//   opcode_i   IR[31:26]
//   funct_i    IR[5:0]
//   class_o    one-hot instruction class (exactly one field set)
//   r_alu_op_o ALU operation for an r_alu class instruction (ADD otherwise)
module mc_instr_class
    import mc_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_t class_o,
    output alu_op_e      r_alu_op_o
);

    always_comb begin
        class_o    = '0;
        r_alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: begin class_o.r_alu = 1'b1; r_alu_op_o = ALU_ADD; end
                    FN_SUBU: begin class_o.r_alu = 1'b1; r_alu_op_o = ALU_SUB; end
                    FN_SLL:  begin class_o.r_alu = 1'b1; r_alu_op_o = ALU_SLL; end
                    FN_JR:   class_o.jr  = 1'b1;
                    default: class_o.bad = 1'b1;
                endcase
            end
            OP_ORI:  class_o.ori = 1'b1;
            OP_LUI:  class_o.lui = 1'b1;
            OP_LW:   class_o.lw  = 1'b1;
            OP_SW:   class_o.sw  = 1'b1;
            OP_BEQ:  class_o.beq = 1'b1;
            OP_JAL:  class_o.jal = 1'b1;
            default: class_o.bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit (Moore FSM; pc_write in BRANCH follows `equal`).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   opcode, funct, equal   IR fields and ALU equal flag
//   pc_write, ir_write, reg_write, mem_write     datapath write enables
//   alu_src_a, alu_src_b, alu_op, shamt_sel      ALU operand / operation selects
//   reg_dst, mem_to_reg, pc_src                  datapath mux selects
//   instr_done             last cycle of a legal instruction
//   illegal                DECODE cycle of an unsupported instruction
module mc_ctrl_fsm #(
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                equal,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_write,
    output logic                alu_src_a,
    output logic [2:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                shamt_sel,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          pc_src,
    output logic                instr_done,
    output logic                illegal
);
    import mc_pkg::*;

    state_e       state_q, state_d;
    instr_class_t cls;
    alu_op_e      r_alu_op;
    alu_op_e      alu_op_w;

    mc_instr_class u_class (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .class_o    (cls),
        .r_alu_op_o (r_alu_op)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign alu_op = ALU_OP_W'(alu_op_w);

    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        alu_op_w   = ALU_ADD;
        shamt_sel  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALU;
        pc_src     = PC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        // Outputs stay at their zero defaults for the whole reset cycle so a
        // half-finished instruction cannot strobe a write.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    state_d   = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_SEXT_SH;
                    if      (cls.r_alu)          state_d = S_EXEC_R;
                    else if (cls.jr)             state_d = S_JR;
                    else if (cls.ori || cls.lui) state_d = S_EXEC_I;
                    else if (cls.lw || cls.sw)   state_d = S_ADDR;
                    else if (cls.beq)            state_d = S_BRANCH;
                    else if (cls.jal)            state_d = S_JAL;
                    else begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_REG;
                    alu_op_w  = r_alu_op;
                    state_d   = S_WB_R;
                end
                S_WB_R: begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RD;
                    instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_ZEXT;
                    if (cls.lui) begin
                        alu_op_w  = ALU_SLL;
                        shamt_sel = 1'b1;
                    end else begin
                        alu_op_w  = ALU_OR;
                    end
                    state_d = S_WB_I;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDR: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_SEXT;
                    state_d   = cls.lw ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: state_d = S_WB_MEM;
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = WB_DM;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_REG;
                    alu_op_w   = ALU_SUB;
                    pc_src     = PC_ALUOUT;
                    pc_write   = equal;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = WB_PC;
                    pc_write   = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                end
                S_JR: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_REGA;
                    instr_done = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       equal;
    logic       pc_write, ir_write, reg_write, mem_write, alu_src_a, shamt_sel;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] reg_dst, mem_to_reg, pc_src;
    logic       instr_done, illegal;

    int errors = 0;
    int checks = 0;

    mc_ctrl_fsm #(.ALU_OP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .equal      (equal),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .shamt_sel  (shamt_sel),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] all_out();
        return {pc_write, ir_write, reg_write, mem_write, alu_src_a, alu_src_b,
                alu_op, shamt_sel, reg_dst, mem_to_reg, pc_src, instr_done, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // FETCH cycle: ir_write, pc_write, srcB=4 must be visible.
    task automatic expect_fetch(input string tag);
        checks++;
        if ({ir_write, pc_write, alu_src_b, pc_src} !== {1'b1, 1'b1, 3'b001, 2'b00}) begin
            errors++;
            $display("FAIL %s fetch: got ir=%b pc=%b srcb=%b pcsrc=%b want 1 1 001 00",
                     tag, ir_write, pc_write, alu_src_b, pc_src);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'b000000; funct = 6'b100001; equal = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin errors++; $display("FAIL reset_t0 outs=%h want 0", all_out()); end
        step();
        checks++;
        if (all_out() !== '0) begin errors++; $display("FAIL reset_c1 outs=%h want 0", all_out()); end
        step();
        checks++;
        if (all_out() !== '0) begin errors++; $display("FAIL reset_c2 outs=%h want 0", all_out()); end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_addu();
        int done_cnt = 0;
        opcode = 6'b000000; funct = 6'b100001;
        expect_fetch("addu_c1"); done_cnt += int'(instr_done);
        step();
        checks++;
        if ({ir_write, alu_src_a, alu_src_b, alu_op} !== {1'b0, 1'b0, 3'b100, 4'b0000}) begin
            errors++; $display("FAIL addu_decode ir=%b a=%b b=%b op=%b want 0 0 100 0000", ir_write, alu_src_a, alu_src_b, alu_op);
        end
        done_cnt += int'(instr_done);
        step();
        checks++;
        if ({alu_src_a, alu_src_b, alu_op, reg_write} !== {1'b1, 3'b000, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL addu_exec a=%b b=%b op=%b rw=%b want 1 000 0000 0", alu_src_a, alu_src_b, alu_op, reg_write);
        end
        done_cnt += int'(instr_done);
        step();
        checks++;
        if ({reg_write, reg_dst, mem_to_reg} !== {1'b1, 2'b01, 2'b00}) begin
            errors++; $display("FAIL addu_wb rw=%b dst=%b m2r=%b want 1 01 00", reg_write, reg_dst, mem_to_reg);
        end
        done_cnt += int'(instr_done);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL addu_done_count got %0d want 1", done_cnt); end
        step();
        expect_fetch("addu_end");
    endtask

    task automatic test_beq();
        logic exp_pw;
        for (int i = 0; i < 2; i++) begin
            exp_pw = (i == 0);
            opcode = 6'b000100; funct = 6'b000000; equal = exp_pw;
            step(); step();
            checks++;
            if ({pc_write, pc_src, alu_op, alu_src_a, instr_done} !== {exp_pw, 2'b01, 4'b0001, 1'b1, 1'b1}) begin
                errors++; $display("FAIL beq%0d_branch pw=%b pcsrc=%b op=%b a=%b done=%b want %b 01 0001 1 1",
                                   i, pc_write, pc_src, alu_op, alu_src_a, instr_done, exp_pw);
            end
            step();
            expect_fetch("beq_end");
        end
        equal = 1'b0;
    endtask

    task automatic test_lw_sw();
        int mw_cnt = 0;
        opcode = 6'b100011;
        step(); step();
        checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 3'b010, 4'b0000}) begin
            errors++; $display("FAIL lw_addr a=%b b=%b op=%b want 1 010 0000", alu_src_a, alu_src_b, alu_op);
        end
        step();
        checks++;
        if ({reg_write, mem_write, instr_done} !== 3'b000) begin
            errors++; $display("FAIL lw_memrd rw=%b mw=%b done=%b want 000", reg_write, mem_write, instr_done);
        end
        step();
        checks++;
        if ({reg_write, reg_dst, mem_to_reg, instr_done} !== {1'b1, 2'b00, 2'b01, 1'b1}) begin
            errors++; $display("FAIL lw_wb rw=%b dst=%b m2r=%b done=%b want 1 00 01 1", reg_write, reg_dst, mem_to_reg, instr_done);
        end
        step();
        expect_fetch("lw_end");
        opcode = 6'b101011;
        for (int c = 1; c <= 4; c++) begin
            if (mem_write === 1'b1) mw_cnt += (c == 4) ? 1 : 10;
            if (c < 4) step();
        end
        checks++;
        if (mw_cnt !== 1) begin errors++; $display("FAIL sw_memwrite code=%0d want 1 (cycle 4 only)", mw_cnt); end
        checks++;
        if ({instr_done, reg_write} !== 2'b10) begin
            errors++; $display("FAIL sw_done done=%b rw=%b want 1 0", instr_done, reg_write);
        end
        step();
        expect_fetch("sw_end");
    endtask

    task automatic test_lui();
        opcode = 6'b001111;
        step(); step();
        checks++;
        if ({alu_op, shamt_sel, alu_src_b, alu_src_a} !== {4'b0011, 1'b1, 3'b011, 1'b1}) begin
            errors++; $display("FAIL lui_exec op=%b sh=%b b=%b a=%b want 0011 1 011 1", alu_op, shamt_sel, alu_src_b, alu_src_a);
        end
        step();
        checks++;
        if ({reg_write, reg_dst, mem_to_reg, instr_done} !== {1'b1, 2'b00, 2'b00, 1'b1}) begin
            errors++; $display("FAIL lui_wb rw=%b dst=%b m2r=%b done=%b want 1 00 00 1", reg_write, reg_dst, mem_to_reg, instr_done);
        end
        step();
        expect_fetch("lui_end");
        opcode = 6'b001101;
        step(); step();
        checks++;
        if ({alu_op, shamt_sel, alu_src_b} !== {4'b0010, 1'b0, 3'b011}) begin
            errors++; $display("FAIL ori_exec op=%b sh=%b b=%b want 0010 0 011", alu_op, shamt_sel, alu_src_b);
        end
        step(); step();
        expect_fetch("ori_end");
    endtask

    task automatic test_jal_jr();
        opcode = 6'b000011;
        step(); step();
        checks++;
        if ({reg_write, reg_dst, mem_to_reg, pc_src, pc_write, instr_done} !== {1'b1, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1}) begin
            errors++; $display("FAIL jal rw=%b dst=%b m2r=%b pcsrc=%b pw=%b done=%b want 1 10 10 10 1 1",
                               reg_write, reg_dst, mem_to_reg, pc_src, pc_write, instr_done);
        end
        step();
        expect_fetch("jal_end");
        opcode = 6'b000000; funct = 6'b001000;
        step(); step();
        checks++;
        if ({pc_src, pc_write, reg_write, instr_done} !== {2'b11, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL jr pcsrc=%b pw=%b rw=%b done=%b want 11 1 0 1", pc_src, pc_write, reg_write, instr_done);
        end
        step();
        expect_fetch("jr_end");
    endtask

    task automatic test_nop_sll();
        opcode = 6'b000000; funct = 6'b000000;
        step(); step();
        checks++;
        if ({alu_op, shamt_sel, alu_src_a} !== {4'b0011, 1'b0, 1'b1}) begin
            errors++; $display("FAIL nop_exec op=%b sh=%b a=%b want 0011 0 1", alu_op, shamt_sel, alu_src_a);
        end
        step();
        checks++;
        if ({reg_write, reg_dst} !== {1'b1, 2'b01}) begin
            errors++; $display("FAIL nop_wb rw=%b dst=%b want 1 01", reg_write, reg_dst);
        end
        step();
        expect_fetch("nop_end");
    endtask

    task automatic test_illegal_reset();
        opcode = 6'b111111; funct = 6'b000000;
        step();
        checks++;
        if ({illegal, instr_done} !== 2'b10) begin
            errors++; $display("FAIL illegal_decode ill=%b done=%b want 1 0", illegal, instr_done);
        end
        step();
        expect_fetch("illegal_end");
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse ill=%b want 0", illegal); end
        opcode = 6'b000000; funct = 6'b100110;
        step();
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_funct ill=%b want 1", illegal); end
        step();
        opcode = 6'b101011;
        step(); step(); step();
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL sw2_memwr mw=%b want 1", mem_write); end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_write, instr_done} !== 2'b00) begin
            errors++; $display("FAIL reset_in_memwr mw=%b done=%b want 0 0", mem_write, instr_done);
        end
        step();
        reset = 1'b0;
        #1;
        expect_fetch("after_reset");
    endtask

    initial begin
        test_reset();
        test_addu();
        test_beq();
        test_lw_sw();
        test_lui();
        test_jal_jr();
        test_nop_sll();
        test_illegal_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
